// File: rtl/program_counter.sv
// Fetch program counter: BOOT/RUN/HALTED control with sequential, branch,
// J-type and register-indirect next-PC selection plus misaligned-jr flagging.
module program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        addr_error
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OFF_W = 16;
  localparam int unsigned IDX_W = 26;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            addr_error_q, addr_error_d;

  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] jr_tgt;

  // Candidate targets, all derived from the current fetch address.
  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    branch_tgt = pc_plus4 + {{(XLEN-OFF_W-2){branch_offset[OFF_W-1]}}, branch_offset, 2'b00};
    jump_tgt   = {pc_plus4[XLEN-1:XLEN-4], jump_index[IDX_W-1:0], 2'b00};
    jr_tgt     = {reg_target[XLEN-1:2], 2'b00};
  end

  // Next state / next PC; halt and stall both hold, with halt taking precedence.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_error_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = pc_plus4;
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          if (jump_reg) begin
            pc_d         = jr_tgt;
            addr_error_d = |reg_target[1:0];
          end else if (jump) begin
            pc_d = jump_tgt;
          end else if (branch_taken) begin
            pc_d = branch_tgt;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC_ALIGNED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC_ALIGNED;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_error_q <= addr_error_d;
    end
  end

  // A stalled fetch still presents a valid (repeated) address.
  always_comb begin
    pc          = pc_q;
    fetch_valid = (state_q == RUN) && !halt;
    addr_error  = addr_error_q;
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vectors plus randomized
// traffic compared every cycle against an arithmetic next-PC model.
module tb_program_counter;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        halt = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, addr_error;

  int errors = 0;
  int checks = 0;

  program_counter #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .addr_error   (addr_error)
  );

  always #5 clk = ~clk;

  typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode = M_BOOT;
  logic [31:0] m_pc   = '0;
  logic        m_err  = 1'b0;
  logic        m_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the PC must become after each edge.
  always @(posedge clk) begin : model
    logic [31:0] npc;
    mode_t       nmode;
    logic        nerr;
    npc   = m_pc;
    nmode = m_mode;
    nerr  = 1'b0;
    if (reset) begin
      npc   = RST_PC;
      nmode = M_BOOT;
    end else if (m_mode == M_BOOT) begin
      nmode = M_RUN;
      npc   = m_pc + 32'd4;
    end else if (m_mode == M_RUN) begin
      if (halt) begin
        nmode = M_HALT;
      end else if (!stall) begin
        if (jump_reg) begin
          npc  = reg_target - (reg_target % 32'd4);
          nerr = (reg_target % 32'd4) != 32'd0;
        end else if (jump) begin
          npc = ((m_pc + 32'd4) & 32'hF000_0000) + 32'(jump_index) * 32'd4;
        end else if (branch_taken) begin
          npc = m_pc + 32'd4 + 32'($signed(branch_offset)) * 32'd4;
        end else begin
          npc = m_pc + 32'd4;
        end
      end
    end
    m_pc   <= npc;
    m_mode <= nmode;
    m_err  <= nerr;
    m_seen <= m_seen | reset;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_seen) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN && !halt));
      chk("addr_error", 32'(addr_error), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    jump_reg = 1'b0; halt = 1'b0;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    idle();
    jump_reg = 1'b1; reg_target = tgt;
    cyc();
    jump_reg = 1'b0;
  endtask

  initial begin
    // Reset then free-run: 0 (reset), 0 (BOOT), 4, 8, 12.
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    idle();
    chk("boot_pc", pc, 32'h0);
    chk("boot_fv", 32'(fetch_valid), 32'h0);
    cyc(); chk("run1_pc", pc, 32'h4); chk("run1_fv", 32'(fetch_valid), 32'h1);
    cyc(); chk("run2_pc", pc, 32'h8);
    cyc(); chk("run3_pc", pc, 32'hC);

    // Branches from 0x10: backward -4 words and forward +3 words.
    cyc(); chk("at_10", pc, 32'h10);
    branch_taken = 1'b1; branch_offset = 16'hFFFC;
    cyc(); chk("br_back", pc, 32'h4);
    jr_to(32'h10); chk("jr_10", pc, 32'h10);
    branch_taken = 1'b1; branch_offset = 16'h0003;
    cyc(); chk("br_fwd", pc, 32'h20);

    // Jump beats branch.
    jr_to(32'h4000_0000); chk("jr_4000", pc, 32'h4000_0000);
    jump = 1'b1; jump_index = 26'h000_0040; branch_taken = 1'b1; branch_offset = 16'h0100;
    cyc(); chk("jump_wins", pc, 32'h4000_0100);

    // Misaligned jr flags for exactly one cycle; stalled jr is discarded.
    jr_to(32'h0000_1002);
    chk("jr_mis_pc", pc, 32'h1000); chk("jr_mis_err", 32'(addr_error), 32'h1);
    cyc(); chk("err_clear", 32'(addr_error), 32'h0); chk("after_err_pc", pc, 32'h1004);
    stall = 1'b1; jump_reg = 1'b1; reg_target = 32'h0000_2003;
    chk("stall_fv", 32'(fetch_valid), 32'h1);
    cyc(); chk("stall_pc", pc, 32'h1004); chk("stall_err", 32'(addr_error), 32'h0);

    // Wrap at the top of the address space, then halt.
    jr_to(32'hFFFF_FFFC); chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_plus4", pc_plus4, 32'h0);
    cyc(); chk("wrap_pc", pc, 32'h0);
    cyc(); chk("pre_halt_pc", pc, 32'h4);
    halt = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      halt = i[0]; branch_taken = 1'b1; jump = i[1]; jump_reg = i[2];
      reg_target = 32'h0000_3003; jump_index = 26'h3FF_FFFF;
      #1;
      chk("halt_fv", 32'(fetch_valid), 32'h0);
      cyc(); chk("halt_pc", pc, 32'h4);
    end

    // Reset out of HALTED, and reset during a stalled redirect.
    idle(); reset = 1'b1; jump_reg = 1'b1; reg_target = 32'h0000_5000;
    cyc(); chk("rst_halt_pc", pc, RST_PC); chk("rst_halt_fv", 32'(fetch_valid), 32'h0);
    idle();
    cyc(); chk("reboot_pc", pc, 32'h4);
    stall = 1'b1; reset = 1'b1; jump_reg = 1'b1; reg_target = 32'h0000_6000;
    cyc(); idle();
    chk("rst_stall_pc", pc, RST_PC);
    cyc(); chk("rst_stall_run", pc, 32'h4);

    // Randomized traffic checked by the every-cycle comparator.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      halt          = ($urandom_range(0, 79) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      jump_reg      = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      jump_index    = 26'($urandom);
      reg_target    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
Parameters:
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the address loaded into the PC on reset.
Ports:
REQ-002 SHALL provide clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide stall  input  1  hold the current PC this cycle.
REQ-005 SHALL provide branch_taken  input  1  load the branch target.
REQ-006 SHALL provide branch_offset  input  16  signed word offset, relative to PC+4.
REQ-007 SHALL provide jump  input  1  load the J-type target.
REQ-008 SHALL provide jump_index  input  26  J-type instruction index field.
REQ-009 SHALL provide jump_reg  input  1  load the register target (jr).
REQ-010 SHALL provide reg_target  input  32  register value for jr.
REQ-011 SHALL provide halt  input  1  stop fetching until the next reset.
REQ-012 SHALL provide pc  output  32  address of the current fetch.
REQ-013 SHALL provide pc_plus4  output  32  pc + 4, combinational from pc.
REQ-014 SHALL provide fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-015 SHALL provide addr_error  output  1  one-cycle pulse when a misaligned jr target is loaded.

Function
REQ-016 SHALL implement a three-state FSM: BOOT, RUN and HALTED.
REQ-017 BOOT SHALL last exactly one cycle after reset deasserts, with fetch_valid=0 and pc held, then go to RUN.
REQ-018 RUN SHALL go to HALTED on a cycle where halt=1; HALTED SHALL be left only by reset.
REQ-019 In HALTED, pc SHALL be frozen, fetch_valid=0, and all control inputs SHALL be ignored.
REQ-020 fetch_valid SHALL be 1 in RUN when halt=0; it SHALL remain 1 during stall, because the same address is re-presented.
REQ-021 In RUN, the next-PC priority SHALL be, highest first: halt (hold) > stall (hold) > jump_reg > jump > branch_taken > sequential (pc_plus4).
REQ-022 pc_plus4 SHALL equal pc + 32'd4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-023 The branch target SHALL be pc_plus4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}), modulo 2^32.
REQ-024 The jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-025 The jr target SHALL be {reg_target[31:2], 2'b00}.
REQ-026 addr_error SHALL be 1 for exactly the cycle after a jr load in which reg_target[1:0]!=0, and 0 otherwise.
REQ-027 The control-to-pc latency SHALL be one cycle: inputs sampled at edge N appear on pc after edge N.
REQ-028 stall with branch_taken/jump/jump_reg asserted simultaneously SHALL hold pc and discard the redirect; upstream must re-present it.
REQ-029 pc[1:0] SHALL always be 2'b00.

Reset
REQ-030 reset=1 at a rising edge SHALL set pc=RESET_PC, state=BOOT, fetch_valid=0 and addr_error=0, overriding every other input.
REQ-031 Reset asserted mid-operation (RUN or HALTED, or during stall) SHALL take effect at the next edge, with no residual redirect applied afterwards.
REQ-032 While reset is held, outputs SHALL remain at their reset values; pc_plus4 SHALL read RESET_PC+4.

Verification
REQ-033 Reset then 4 free-running cycles: pc = 0,0(BOOT),4,8,12; fetch_valid = 0,0,1,1,1.
REQ-034 At pc=32'h0000_0010, branch_taken=1 with branch_offset=16'hFFFC: the next pc = 32'h0000_0004; with offset 16'h0003: the next pc = 32'h0000_0020.
REQ-035 At pc=32'h4000_0000, jump=1 with jump_index=26'h000_0040 and branch_taken=1 together: the next pc = 32'h4000_0100 (jump wins).
REQ-036 jump_reg=1 with reg_target=32'h0000_1002: the next pc = 32'h0000_1000 and addr_error pulses for 1 cycle; stall=1 with jump_reg=1: pc is unchanged and addr_error=0.
REQ-037 Load pc=32'hFFFF_FFFC via jr and run 1 cycle: pc=0. Then assert halt: pc is frozen and fetch_valid=0 for 10 cycles despite branch/jump inputs. Then assert reset: pc=RESET_PC, followed by the BOOT cycle.
